wave_capture_trig: RTL
======================

Name: wave_capture_trig

Overview:
- Parametrised next-generation waveform capture for the scope display path. Sits between the audio sample stream and the double-buffered display RAM read by wave_display.
- Adds over the current capture block:
  - programmable trigger level;
  - rising/falling edge select;
  - auto-trigger timeout (free-run when no edge arrives);
  - sample decimation;
  - generic sample/display widths and capture depth;
  - frame status outputs.

Parameters:
- SAMPLE_W, 16, input sample width (signed two's complement).
- DISP_W, 8, stored sample width (offset binary, top bits of sample); DISP_W <= SAMPLE_W.
- DEPTH_LOG2, 8, log2 of samples per frame (frame = 2**DEPTH_LOG2 entries per half-buffer).
- TIMEOUT_W, 12, width of auto-trigger timeout counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- new_sample_ready  in  1  one-cycle pulse, new_sample_in valid.
- new_sample_in  in  SAMPLE_W  signed audio sample.
- wave_display_idle  in  1  high while display is not rendering.
- trig_level  in  SAMPLE_W  signed trigger threshold.
- trig_falling  in  1  0 = rising edge, 1 = falling edge.
- auto_en  in  1  enable auto-trigger on timeout.
- auto_timeout  in  TIMEOUT_W  samples to wait in ARMED before forced trigger; 0 = auto disabled.
- decim  in  4  keep 1 of every decim samples in ACTIVE; 0 treated as 1.
- write_address  out  DEPTH_LOG2+1  {~read_index, index}.
- write_enable  out  1  RAM write strobe.
- write_sample  out  DISP_W  offset-binary sample.
- read_index  out  1  half of RAM the display reads.
- frame_done  out  1  one-cycle pulse on entry to WAIT.
- frame_auto  out  1  last completed frame was auto-triggered.

Behaviour:
- Reset: asynchronous, active-low. All of the following are 0, with the state in ARMED:
  - state, index, prev_sample, prev_valid, decim counter, timeout counter;
  - read_index, frame_done, frame_auto, write_enable.
- Reset asserted mid-frame aborts the frame immediately. No write occurs while reset_n = 0.
- prev_sample and prev_valid:
  - On every new_sample_ready, prev_sample <= new_sample_in and prev_valid <= 1, in all states.
  - prev_valid stays 1 until reset.
- Edge detect (combinational, qualified by new_sample_ready && prev_valid && state == ARMED):
  - rising: prev_sample < trig_level && new_sample_in >= trig_level (signed compare);
  - falling: prev_sample >= trig_level && new_sample_in < trig_level.
- Auto-trigger:
  - In ARMED, the timeout counter increments on each new_sample_ready.
  - Auto fires when auto_en = 1, auto_timeout != 0, and new_sample_ready with counter == auto_timeout-1.
  - If an edge and the timeout hit occur on the same sample, it counts as an edge trigger (frame_auto = 0).
- trigger = edge || auto. On a trigger sample:
  - the triggering sample is written at index 0, so write_enable is combinational from the pulse;
  - index <= 1, decim counter <= 0;
  - decim is latched into decim_r;
  - frame_auto_pending <= auto && !edge;
  - state goes to ACTIVE.
- States:
  - ARMED -> ACTIVE on trigger.
  - ACTIVE -> WAIT on the write of index 2**DEPTH_LOG2-1.
  - WAIT -> ARMED when wave_display_idle = 1.
  - Unreachable encoding -> ARMED.
- ACTIVE:
  - On each new_sample_ready, the decim counter increments and wraps at decim_r-1.
  - A write occurs when the counter wraps (i.e. on every decim_r-th sample after the trigger, trigger = sample 0); index increments on each write.
  - decim_r = 1 means every sample is written.
  - Config inputs changed mid-frame do not affect the frame in progress.
- WAIT:
  - If wave_display_idle = 1: read_index toggles, state goes to ARMED, and the timeout counter is cleared, all on the same edge.
  - No writes occur in WAIT.
- Outputs:
  - write_enable = new_sample_ready && (trigger || (state == ACTIVE && decim wrap)).
  - write_address = {~read_index, index}, with index 0 during a trigger write.
  - write_sample = new_sample_in[SAMPLE_W-1 -: DISP_W] with MSB inverted. For 16/8, 0x8000 -> 0x00, 0x0000 -> 0x80, 0x7FFF -> 0xFF. When write_enable = 0, the value is don't-care.
- Frame status:
  - frame_done is registered: it pulses 1 cycle on the edge where the state becomes WAIT.
  - frame_auto updates on that same edge from frame_auto_pending.
- The index counter does not wrap beyond the frame: the final write forces WAIT, and index is cleared in ARMED.
- Latency: write is same-cycle as the qualifying new_sample_ready; state and status are one cycle later.

Test Plan:
- Reset, then stream sine samples -32000..+32000 with trig_level = 0 and trig_falling = 0. Expected:
  - the first write is the first sample >= 0 after a negative one, at address 0x100 ({~0, 0x00});
  - 256 consecutive writes occur at 0x100..0x1FF;
  - frame_done pulses once after the write to 0x1FF.
- Hold in WAIT with wave_display_idle = 0 for 50 samples, then assert it:
  - no writes during the hold;
  - read_index goes 0 -> 1;
  - the next frame writes at 0x000..0x0FF.
- trig_falling = 1, trig_level = 0x1000, ramp down from 0x2000. Expected: trigger on the first sample < 0x1000; a sample equal to 0x1000 does not trigger.
- Constant input 0x0100, trig_level = 0, auto_en = 1, auto_timeout = 10. Expected:
  - forced trigger on the 10th sample in ARMED;
  - frame_auto = 1 after frame_done.
  - Repeat with auto_timeout = 0: no trigger ever.
- decim = 4 with a ramp of +1 per sample starting at the trigger. Expected:
  - stored samples are trigger, trigger+4, trigger+8, ...;
  - changing decim to 2 mid-frame has no effect on the current frame.
- Assert reset_n asynchronously mid-ACTIVE at index 0x37. Expected:
  - outputs clear immediately without waiting for clk, and read_index = 0;
  - after release, the first sample cannot trigger (prev_valid = 0);
  - the next frame starts at index 0.

Source files
------------

// File: rtl/wave_capture_trig_if.sv
// Sample stream in, display RAM write port out, for the triggered waveform capture.
interface wave_capture_trig_if #(
  parameter int SAMPLE_W   = 16,
  parameter int DISP_W     = 8,
  parameter int DEPTH_LOG2 = 8
);
  logic                  new_sample_ready;
  logic [SAMPLE_W-1:0]   new_sample_in;
  logic                  wave_display_idle;
  logic [DEPTH_LOG2:0]   write_address;
  logic                  write_enable;
  logic [DISP_W-1:0]     write_sample;
  logic                  read_index;

  modport master (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );

  modport slave (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );
endinterface

// File: rtl/wave_capture_trig.sv
// Triggered waveform capture into a double-buffered display RAM: level/edge trigger,
// auto-trigger timeout, decimation and frame status.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_ARMED  | looking for a trigger edge or auto timeout; index held at 0
//   ST_ACTIVE | writing every decim_r-th sample into the back half
//   ST_WAIT   | frame complete, waiting for the display to go idle to swap
module wave_capture_trig #(
  parameter int SAMPLE_W   = 16,
  parameter int DISP_W     = 8,
  parameter int DEPTH_LOG2 = 8,
  parameter int TIMEOUT_W  = 12
) (
  input  logic                        clk,
  input  logic                        reset_n,
  wave_capture_trig_if.slave          bus,
  input  logic signed [SAMPLE_W-1:0]  trig_level,
  input  logic                        trig_falling,
  input  logic                        auto_en,
  input  logic [TIMEOUT_W-1:0]        auto_timeout,
  input  logic [3:0]                  decim,
  output logic                        frame_done,
  output logic                        frame_auto
);
  localparam logic [1:0] ST_ARMED  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  localparam logic [DEPTH_LOG2-1:0] LAST_INDEX = '1;
  localparam logic [DISP_W-1:0]     MSB_FLIP   = DISP_W'(1) << (DISP_W - 1);

  logic [1:0]                  state;
  logic [DEPTH_LOG2-1:0]       index;
  logic signed [SAMPLE_W-1:0]  prev_sample;
  logic signed [SAMPLE_W-1:0]  sample;
  logic                        prev_valid;
  logic [3:0]                  decim_cnt;
  logic [3:0]                  decim_r;
  logic [3:0]                  decim_eff;
  logic [TIMEOUT_W-1:0]        tmo_cnt;
  logic                        read_index_r;
  logic                        frame_auto_pending;
  logic                        armed_sample;
  logic                        edge_hit;
  logic                        auto_hit;
  logic                        trigger;
  logic                        decim_wrap;
  logic                        active_write;
  logic [DEPTH_LOG2-1:0]       index_w;
  logic [DISP_W-1:0]           sample_top;

  assign sample       = $signed(bus.new_sample_in);
  assign armed_sample = (state == ST_ARMED) && bus.new_sample_ready;
  assign decim_eff    = (decim == 4'd0) ? 4'd1 : decim;

  always_comb begin
    edge_hit = 1'b0;
    if (armed_sample && prev_valid) begin
      if (trig_falling)
        edge_hit = (prev_sample >= trig_level) && (sample < trig_level);
      else
        edge_hit = (prev_sample < trig_level) && (sample >= trig_level);
    end
  end

  // Auto is not gated by prev_valid, so reset must block it from writing.
  assign auto_hit     = armed_sample && auto_en && (auto_timeout != '0) &&
                        (tmo_cnt == auto_timeout - TIMEOUT_W'(1));
  assign trigger      = reset_n && (edge_hit || auto_hit);
  assign decim_wrap   = (decim_cnt == decim_r - 4'd1);
  assign active_write = (state == ST_ACTIVE) && bus.new_sample_ready && decim_wrap;

  assign index_w           = trigger ? '0 : index;
  assign sample_top        = bus.new_sample_in[SAMPLE_W-1 -: DISP_W];
  assign bus.write_enable  = trigger || active_write;
  assign bus.write_address = {~read_index_r, index_w};
  assign bus.write_sample  = sample_top ^ MSB_FLIP;
  assign bus.read_index    = read_index_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_ARMED;
      index              <= '0;
      prev_sample        <= '0;
      prev_valid         <= 1'b0;
      decim_cnt          <= '0;
      decim_r            <= 4'd1;
      tmo_cnt            <= '0;
      read_index_r       <= 1'b0;
      frame_auto_pending <= 1'b0;
      frame_done         <= 1'b0;
      frame_auto         <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (bus.new_sample_ready) begin
        prev_sample <= sample;
        prev_valid  <= 1'b1;
      end
      case (state)
        ST_ARMED: begin
          index <= '0;
          if (trigger) begin
            index              <= DEPTH_LOG2'(1);
            decim_cnt          <= '0;
            decim_r            <= decim_eff;
            frame_auto_pending <= auto_hit && !edge_hit;
            state              <= ST_ACTIVE;
          end else if (bus.new_sample_ready) begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (bus.new_sample_ready) begin
            decim_cnt <= decim_wrap ? 4'd0 : decim_cnt + 4'd1;
            if (decim_wrap) begin
              index <= index + DEPTH_LOG2'(1);
              if (index == LAST_INDEX) begin
                state      <= ST_WAIT;
                frame_done <= 1'b1;
                frame_auto <= frame_auto_pending;
              end
            end
          end
        end
        ST_WAIT: begin
          index <= '0;
          if (bus.wave_display_idle) begin
            read_index_r <= ~read_index_r;
            tmo_cnt      <= '0;
            state        <= ST_ARMED;
          end
        end
        default: state <= ST_ARMED;
      endcase
    end
  end
endmodule
